// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared single-port RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module ram_access_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_we,
    input  logic [2*N-1:0] req_addr,
    input  logic [2*N-1:0] req_wdata,
    output logic [1:0]     rsp_valid,
    output logic [N-1:0]   rsp_rdata,
    output logic           busy,
    output logic [N-1:0]   ram_addr,
    output logic [N-1:0]   ram_wdata,
    output logic           ram_we,
    output logic           ram_re,
    input  logic [N-1:0]   ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant;
    logic       hs;
    logic       win;
    logic       owner;
    logic       op_we;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`else
    logic last;

    // On contention the requester that did not win the previous handshake goes next.
    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (hs)
            last <= win;
    end
`endif

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE)
            req_ready = grant;
    end

    assign hs  = |req_ready;
    assign win = req_ready[1];

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        rsp_valid = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (hs)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_we    = op_we;
                ram_re    = !op_we;
                state_nxt = op_we ? IDLE : CAPTURE;
            end
            CAPTURE: state_nxt = RESPOND;
            RESPOND: begin
                rsp_valid = owner ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's command is latched at handshake; RAM pins hold it until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            op_we     <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_rdata <= '0;
        end else begin
            if (hs) begin
                owner     <= win;
                op_we     <= req_we[win];
                ram_addr  <= win ? req_addr[2*N-1:N]  : req_addr[N-1:0];
                ram_wdata <= win ? req_wdata[2*N-1:N] : req_wdata[N-1:0];
            end
            if (state == CAPTURE)
                rsp_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: spec-level model of grants, strobes,
// busy and read responses against a behavioural RAM. Honours RAM_ARB_FIXED_PRIO_EN.
module tb_ram_access_arbiter;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         gap;
    } cmd_t;

    typedef struct {
        int         due;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } stb_t;

    typedef struct {
        int         due;
        int         k;
        logic [7:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_rdata;

    ram_access_arbiter #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data appears the cycle after re is sampled.
    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_we)
            ram_mem[ram_addr] <= ram_wdata;
        if (ram_re)
            ram_rdata <= ram_mem[ram_addr];
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   idle_at = 0;
    int   last_k = 1;
    logic [7:0] ref_mem [256];
    logic [1:0] hs_seen = '0;
    bit   drop_en = 0;
    cmd_t q0[$];
    cmd_t q1[$];
    cmd_t cur[2];
    stb_t stbq[$];
    rsp_t rspq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input int lastk);
        if (v != 2'b11)
            return v;
`ifdef RAM_ARB_FIXED_PRIO_EN
        return 2'b01;
`else
        return (lastk == 0) ? 2'b10 : 2'b01;
`endif
    endfunction

    // Monitor / scoreboard: one evaluation per cycle, away from the active edge.
    always @(negedge clk) begin
        stb_t s;
        rsp_t r;
        logic [1:0] eg;
        logic [1:0] hs;
        bit eb;
        int k;
        cyc++;
        if (stbq.size() > 0 && stbq[0].due == cyc) begin
            s = stbq.pop_front();
            chk("strobe", {ram_we, ram_re}, s.we ? 2'b10 : 2'b01);
            chk("ram_addr", ram_addr, s.addr);
            if (s.we)
                chk("ram_wdata", ram_wdata, s.wdata);
        end else begin
            chk("no_strobe", {ram_we, ram_re}, 2'b00);
        end
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
            r = rspq.pop_front();
            chk("rsp_valid", rsp_valid, (r.k == 1) ? 2'b10 : 2'b01);
            chk("rsp_rdata", rsp_rdata, r.data);
        end else begin
            chk("no_rsp", rsp_valid, 2'b00);
        end
        eb = (cyc < idle_at);
        chk("busy", busy, eb);
        eg = (rst_n && !eb) ? exp_grant(req_valid, last_k) : 2'b00;
        chk("req_ready", req_ready, eg);
        hs = req_valid & req_ready;
        hs_seen = hs;
        if (hs == 2'b01 || hs == 2'b10) begin
            k = hs[1] ? 1 : 0;
            last_k = k;
            s.due   = cyc + 1;
            s.we    = req_we[k];
            s.addr  = req_addr[k*8 +: 8];
            s.wdata = req_wdata[k*8 +: 8];
            stbq.push_back(s);
            if (s.we) begin
                ref_mem[s.addr] = s.wdata;
                idle_at = cyc + 2;
            end else begin
                r.due  = cyc + 3;
                r.k    = k;
                r.data = ref_mem[s.addr];
                rspq.push_back(r);
                idle_at = cyc + 4;
            end
        end
        if (!rst_n) begin
            for (int i = rspq.size() - 1; i >= 0; i--)
                if (rspq[i].due > cyc)
                    rspq.delete(i);
            for (int i = stbq.size() - 1; i >= 0; i--)
                if (stbq[i].due > cyc)
                    stbq.delete(i);
            if (idle_at > cyc + 1)
                idle_at = cyc + 1;
            last_k = 1;
        end
    end

    // Requester drivers: present queued commands, hold fields until accepted.
    always @(posedge clk) begin
        cmd_t c;
        int sz;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (req_valid[k] && hs_seen[k]) begin
                req_valid[k] = 1'b0;
            end else if (req_valid[k] && drop_en && $urandom_range(0, 7) == 0) begin
                req_valid[k] = 1'b0;
                c = cur[k];
                c.gap = 1;
                if (k == 0) q0.push_front(c); else q1.push_front(c);
            end
            sz = (k == 0) ? q0.size() : q1.size();
            if (!req_valid[k] && sz > 0) begin
                c = (k == 0) ? q0[0] : q1[0];
                if (c.gap > 0) begin
                    c.gap--;
                    if (k == 0) q0[0] = c; else q1[0] = c;
                end else begin
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    cur[k]               = c;
                    req_we[k]            = c.we;
                    req_addr[k*8 +: 8]   = c.addr;
                    req_wdata[k*8 +: 8]  = c.wdata;
                    req_valid[k]         = 1'b1;
                end
            end
        end
    end

    function automatic cmd_t mk(input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input int gap);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.gap = gap;
        return c;
    endfunction

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            done = (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 &&
                    rspq.size() == 0 && stbq.size() == 0 && cyc >= idle_at);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d actual=pending expected=idle", cyc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        bit got;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i ^ 8'h5A);
            ref_mem[i] = 8'(i ^ 8'h5A);
        end

        // Reset with both requesters pending; req0 must win first after release.
        q0.push_back(mk(1'b1, 8'h10, 8'hA5, 0));
        q0.push_back(mk(1'b0, 8'h10, 8'h00, 0));
        q1.push_back(mk(1'b0, 8'h10, 8'h00, 0));
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            {req_ready, rsp_valid, rsp_rdata, busy, ram_we, ram_re, ram_addr, ram_wdata}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain();

        // Contention on reads.
        q0.push_back(mk(1'b1, 8'h01, 8'h11, 0));
        q1.push_back(mk(1'b1, 8'h02, 8'h22, 0));
        drain();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 8'h01, 8'h00, 0));
            q1.push_back(mk(1'b0, 8'h02, 8'h00, 0));
        end
        drain();

        // Back-to-back writes from requester 1, then readback.
        for (int i = 0; i < 8; i++)
            q1.push_back(mk(1'b1, 8'(i), 8'(i + 1), 0));
        for (int i = 0; i < 8; i++)
            q1.push_back(mk(1'b0, 8'(i), 8'h00, 0));
        drain();

        // Reset during the CAPTURE cycle of a read.
        q0.push_back(mk(1'b1, 8'h20, 8'h3C, 0));
        drain();
        q0.push_back(mk(1'b0, 8'h20, 8'h00, 0));
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            got = hs_seen[0];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL midread_hs cyc=%0d actual=none expected=handshake", cyc);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q0.push_back(mk(1'b0, 8'h20, 8'h00, 0));
        drain();

        // Randomised mix with gaps, aliasing addresses and abandoned requests.
        drop_en = 1;
        for (int i = 0; i < 40; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                            8'($urandom), $urandom_range(0, 3)));
            q1.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                            8'($urandom), $urandom_range(0, 3)));
        end
        drain();
        drop_en = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
